// File: rtl/dec3to8_strobe_if.sv
// Handshake and strobe bundle for dec3to8_strobe: channel-select source on
// the master side, decoder on the slave side.
interface dec3to8_strobe_if;
    logic       en;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] d;
    logic [7:0] q;
    logic       busy;
    logic       done;

    modport master (
        output en, in_valid, d,
        input  in_ready, q, busy, done
    );

    modport slave (
        input  en, in_valid, d,
        output in_ready, q, busy, done
    );
endinterface

// File: rtl/dec3to8_strobe.sv
// Registered 3-to-8 decoder: accepts an index over valid/ready, drives a timed
// one-hot strobe, then holds an idle gap before the next index.
//
//   state | meaning
//   IDLE  | waiting for a handshake, q = 0
//   DRIVE | one-hot strobe on q, cnt counts down the pulse width
//   GAP   | forced idle after a normal pulse, cnt counts down the gap
module dec3to8_strobe #(
    parameter int PULSE_W = 4,
    parameter int GAP_W   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    dec3to8_strobe_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] PULSE_M1 = 8'(PULSE_W - 1);
    localparam logic [7:0] GAP_M1   = 8'(GAP_W - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [7:0] r_q;
    logic [2:0] r_idx;
    logic       r_busy;
    logic       r_done;

    state_t     w_state_nxt;
    logic [7:0] w_cnt_nxt;
    logic [7:0] w_q_nxt;
    logic [2:0] w_idx_nxt;
    logic       w_busy_nxt;
    logic       w_done_nxt;
    logic       w_ready;
    logic       w_fire;

    // rst_n folded in so a source never sees ready while the block is held in reset
    assign w_ready = bus.en & (r_state == IDLE) & rst_n;
    assign w_fire  = bus.in_valid & w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 8'h00;
            r_q     <= 8'h00;
            r_idx   <= 3'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_q     <= w_q_nxt;
            r_idx   <= w_idx_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_q_nxt     = r_q;
        w_idx_nxt   = r_idx;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                w_q_nxt = 8'h00;
                if (w_fire) begin
                    w_idx_nxt   = bus.d;
                    w_q_nxt     = 8'h01 << bus.d;
                    w_cnt_nxt   = PULSE_M1;
                    w_state_nxt = DRIVE;
                    w_busy_nxt  = 1'b1;
                end
            end

            DRIVE: begin
                // abort outranks terminal count, so a dropped en never yields done
                if (!bus.en) begin
                    w_q_nxt     = 8'h00;
                    w_cnt_nxt   = 8'h00;
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                end else if (r_cnt != 8'h00) begin
                    w_cnt_nxt = r_cnt - 8'h01;
                end else begin
                    w_q_nxt    = 8'h00;
                    w_done_nxt = 1'b1;
                    if (GAP_W > 0) begin
                        w_cnt_nxt   = GAP_M1;
                        w_state_nxt = GAP;
                    end else begin
                        w_state_nxt = IDLE;
                        w_busy_nxt  = 1'b0;
                    end
                end
            end

            GAP: begin
                w_q_nxt = 8'h00;
                if (r_cnt != 8'h00) begin
                    w_cnt_nxt = r_cnt - 8'h01;
                end else begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                end
            end

            default: begin
                w_q_nxt     = 8'h00;
                w_cnt_nxt   = 8'h00;
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign bus.in_ready = w_ready;
    assign bus.q        = r_q;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule

// File: tb/tb_dec3to8_strobe.sv
// Scoreboard bench for dec3to8_strobe: DUT A uses PULSE_W=4/GAP_W=2,
// DUT B uses PULSE_W=1/GAP_W=0.
module tb_dec3to8_strobe;

    typedef struct {
        logic [7:0] q;
        int         len;
        logic       dn;
    } exp_t;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   tests;
    int   fails;
    int   cyc_n;

    dec3to8_strobe_if ifa ();
    dec3to8_strobe_if ifb ();

    dec3to8_strobe #(.PULSE_W(4), .GAP_W(2)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_a),
        .bus   (ifa)
    );

    dec3to8_strobe #(.PULSE_W(1), .GAP_W(0)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_b),
        .bus   (ifb)
    );

    exp_t exp_qa[$];
    exp_t exp_qb[$];
    exp_t cur[2];
    logic [7:0] prv[2];
    int   run[2];
    int   zrun[2];
    logic had_norm[2];
    int   min_gap[2];
    int   done_cnt[2];
    int   done_exp[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic mon(input int k, input logic [7:0] q, input logic dn);
        exp_t e;
        if (!$onehot0(q)) chk("onehot", 32'(q), 32'h0);
        if (q != 8'h00 && prv[k] == 8'h00) begin
            if ((k == 0 && exp_qa.size() == 0) || (k == 1 && exp_qb.size() == 0)) begin
                chk("unexpected_strobe", 32'(q), 32'h0);
                e.q = q; e.len = 0; e.dn = 1'b0;
            end else begin
                e = (k == 0) ? exp_qa.pop_front() : exp_qb.pop_front();
                chk(k == 0 ? "strobe_a" : "strobe_b", 32'(q), 32'(e.q));
            end
            if (had_norm[k]) chk("zero_gap_ok", 32'(zrun[k] >= min_gap[k]), 32'h1);
            cur[k] = e;
            run[k] = 1;
            if (dn) chk("done_during_strobe", 32'(dn), 32'h0);
        end else if (q != 8'h00) begin
            if (q != prv[k]) chk("strobe_stable", 32'(q), 32'(prv[k]));
            run[k]++;
            if (dn) chk("done_during_strobe", 32'(dn), 32'h0);
        end else if (prv[k] != 8'h00) begin
            chk(k == 0 ? "pulse_len_a" : "pulse_len_b", 32'(run[k]), 32'(cur[k].len));
            chk(k == 0 ? "done_at_end_a" : "done_at_end_b", 32'(dn), 32'(cur[k].dn));
            had_norm[k] = cur[k].dn;
            zrun[k] = 1;
        end else begin
            zrun[k]++;
            if (dn) chk("spurious_done", 32'(dn), 32'h0);
        end
        if (dn) done_cnt[k]++;
        prv[k] = q;
    endtask

    always @(negedge clk) begin
        mon(0, ifa.q, ifa.done);
        mon(1, ifb.q, ifb.done);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Presents index dv on DUT k, waits (bounded) for ready, records the fire cycle
    task automatic send(input int k, input logic [2:0] dv, input int len,
                        input logic dn, output int t);
        int   w;
        logic rdy;
        exp_t e;
        w = 0;
        if (k == 0) begin ifa.d = dv; ifa.in_valid = 1'b1; end
        else        begin ifb.d = dv; ifb.in_valid = 1'b1; end
        rdy = (k == 0) ? ifa.in_ready : ifb.in_ready;
        while (!rdy && w < 50) begin
            cyc();
            w++;
            rdy = (k == 0) ? ifa.in_ready : ifb.in_ready;
        end
        if (!rdy) chk("ready_timeout", 32'(w), 32'd0);
        @(posedge clk);
        #1;
        t = cyc_n;
        e.q = 8'h01 << dv; e.len = len; e.dn = dn;
        if (k == 0) exp_qa.push_back(e); else exp_qb.push_back(e);
        if (dn) done_exp[k]++;
    endtask

    initial begin
        int t0, t1, ta, tb;
        tests = 0; fails = 0;
        for (int i = 0; i < 2; i++) begin
            prv[i] = 8'h00; run[i] = 0; zrun[i] = 0; had_norm[i] = 1'b0;
            done_cnt[i] = 0; done_exp[i] = 0;
            cur[i].q = 8'h00; cur[i].len = 0; cur[i].dn = 1'b0;
        end
        min_gap[0] = 3;
        min_gap[1] = 1;

        rst_a = 1'b0; rst_b = 1'b0;
        ifa.en = 1'b1; ifa.in_valid = 1'b1; ifa.d = 3'd0;
        ifb.en = 1'b1; ifb.in_valid = 1'b0; ifb.d = 3'd0;
        repeat (3) cyc();
        chk("rst_q", 32'(ifa.q), 32'h0);
        chk("rst_busy", 32'(ifa.busy), 32'h0);
        chk("rst_done", 32'(ifa.done), 32'h0);
        chk("rst_ready", 32'(ifa.in_ready), 32'h0);
        #3;
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.in_valid = 1'b0;
        cyc();
        chk("ready_after_rst_a", 32'(ifa.in_ready), 32'h1);
        chk("ready_after_rst_b", 32'(ifb.in_ready), 32'h1);

        // single decode d=5, then ready timing through the gap
        send(0, 3'd5, 4, 1'b1, t0);
        ifa.in_valid = 1'b0;
        chk("ready_drive", 32'(ifa.in_ready), 32'h0);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk("ready_window", 32'(ifa.in_ready), 32'(k == 6));
            chk("busy_window", 32'(ifa.busy), 32'(k < 6));
        end

        // back-to-back sweep with in_valid held high
        for (int i = 0; i < 8; i++) begin
            send(0, 3'(i), 4, 1'b1, t1);
            chk("handshake_spacing", 32'(t1 - t0), 32'd7);
            t0 = t1;
        end
        ifa.in_valid = 1'b0;
        repeat (8) cyc();

        // abort two cycles into a d=3 pulse
        send(0, 3'd3, 2, 1'b0, t0);
        ifa.in_valid = 1'b0;
        cyc();
        ifa.en = 1'b0;
        cyc();
        chk("abort_q", 32'(ifa.q), 32'h0);
        chk("abort_busy", 32'(ifa.busy), 32'h0);
        chk("abort_ready_en_low", 32'(ifa.in_ready), 32'h0);
        ifa.en = 1'b1;
        #1;
        chk("abort_ready_en_high", 32'(ifa.in_ready), 32'h1);
        send(0, 3'd1, 4, 1'b1, t1);
        chk("abort_rehandshake", 32'(t1 - t0), 32'd3);
        ifa.in_valid = 1'b0;
        repeat (8) cyc();

        // en drops on the cnt==0 DRIVE cycle
        send(0, 3'd2, 4, 1'b0, t0);
        ifa.in_valid = 1'b0;
        repeat (3) cyc();
        ifa.en = 1'b0;
        cyc();
        chk("late_abort_q", 32'(ifa.q), 32'h0);
        chk("late_abort_done", 32'(ifa.done), 32'h0);
        chk("late_abort_busy", 32'(ifa.busy), 32'h0);
        ifa.en = 1'b1;
        repeat (8) cyc();

        // async reset while q=8'h40
        send(0, 3'd6, 2, 1'b0, t0);
        ifa.in_valid = 1'b0;
        cyc();
        #5;
        rst_a = 1'b0;
        #1;
        chk("async_rst_q", 32'(ifa.q), 32'h0);
        chk("async_rst_busy", 32'(ifa.busy), 32'h0);
        chk("async_rst_done", 32'(ifa.done), 32'h0);
        chk("async_rst_ready", 32'(ifa.in_ready), 32'h0);
        #4;
        rst_a = 1'b1;
        cyc();

        // PULSE_W=1, GAP_W=0 stream
        send(1, 3'd7, 1, 1'b1, ta);
        ifb.d = 3'd0;
        send(1, 3'd0, 1, 1'b1, tb);
        ifb.in_valid = 1'b0;
        chk("edge_spacing", 32'(tb - ta), 32'd2);

        repeat (10) cyc();
        chk("queue_a_empty", 32'(exp_qa.size()), 32'd0);
        chk("queue_b_empty", 32'(exp_qb.size()), 32'd0);
        chk("done_count_a", 32'(done_cnt[0]), 32'(done_exp[0]));
        chk("done_count_b", 32'(done_cnt[1]), 32'(done_exp[1]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
